// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 (optionally 8E1) UART receiver with mid-bit sampling
//
// Purpose:
//   Receives serial frames on rx_in: a start bit (0), then 8 data bits LSB first,
//   then an optional even-parity bit, then a stop bit (1). The idle line is high.
//   The line is oversampled with CLKS_PER_BIT clocks per bit and sampled mid-bit.
//   Each good frame updates rx_out and raises done for one cycle.
//
// Configuration macro:
//   UART_RX_PARITY_EN - when defined, frames are 8E1 and parity_err is live;
//                       when undefined, frames are 8N1 and parity_err is tied 0.
//
// Ports:
//   clk         in   1  system clock, all logic on posedge
//   rst_n       in   1  asynchronous active-low reset
//   rx_en       in   1  receiver enable; low forces IDLE
//   rx_in       in   1  serial line, asynchronous to clk
//   rx_out      out  8  last good received byte, held until the next good frame
//   done        out  1  one-cycle pulse when rx_out is updated
//   busy        out  1  high while a frame is in progress (state != IDLE)
//   frame_err   out  1  one-cycle pulse when the stop bit samples 0
//   parity_err  out  1  one-cycle pulse on parity mismatch

module uart_rx #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_en,
  input  logic       rx_in,
  output logic [7:0] rx_out,
  output logic       done,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4,
    WAIT_IDLE  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    STOP_BIT   = 3'd4,
    WAIT_IDLE  = 3'd5
  } state_t;
`endif

  state_t        state;
  logic          rx_meta;
  logic          rx_sync;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

`ifdef UART_RX_PARITY_EN
  logic          parity_bit;
  logic          parity_err_r;

  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Synchronizer resets to the idle line level so reset release never
      // looks like a start bit.
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      state        <= IDLE;
      clk_cnt      <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      rx_out       <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit   <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      rx_meta   <= rx_in;
      rx_sync   <= rx_meta;
      // Status strobes are single-cycle unless re-asserted below.
      done      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif

      if (!rx_en) begin
        state   <= IDLE;
        clk_cnt <= '0;
        bit_idx <= '0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!rx_sync) begin
              state   <= START_BIT;
              clk_cnt <= '0;
              busy    <= 1'b1;
            end
          end

          // Re-check half a bit in; a short low pulse is treated as noise.
          START_BIT: begin
            if (clk_cnt == CNT_HALF) begin
              clk_cnt <= '0;
              bit_idx <= '0;
              if (!rx_sync) begin
                state <= DATA_BITS;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              clk_cnt <= clk_cnt + 1'b1;
            end
          end

          // Counting a full bit from the mid-start point lands mid-bit.
          DATA_BITS: begin
            if (clk_cnt == CNT_LAST) begin
              clk_cnt <= '0;
              shift   <= {rx_sync, shift[7:1]};
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY_BIT;
`else
                state <= STOP_BIT;
`endif
              end
            end else begin
              clk_cnt <= clk_cnt + 1'b1;
            end
          end

`ifdef UART_RX_PARITY_EN
          PARITY_BIT: begin
            if (clk_cnt == CNT_LAST) begin
              clk_cnt    <= '0;
              parity_bit <= rx_sync;
              state      <= STOP_BIT;
            end else begin
              clk_cnt <= clk_cnt + 1'b1;
            end
          end
`endif

          STOP_BIT: begin
            if (clk_cnt == CNT_LAST) begin
              clk_cnt <= '0;
              if (rx_sync) begin
                // Returning to IDLE here lets the next start bit be seen in
                // the same cycle that done is high.
                state <= IDLE;
                busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                if ((^shift) ^ parity_bit) begin
                  parity_err_r <= 1'b1;
                end else begin
                  rx_out <= shift;
                  done   <= 1'b1;
                end
`else
                rx_out <= shift;
                done   <= 1'b1;
`endif
              end else begin
                // Frame error wins over parity; hold off until the line
                // goes high so a break does not retrigger reception.
                frame_err <= 1'b1;
                state     <= WAIT_IDLE;
              end
            end else begin
              clk_cnt <= clk_cnt + 1'b1;
            end
          end

          WAIT_IDLE: begin
            if (rx_sync) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end

          default: begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
